counter_scheduler: RTL and testbench

- Time-shares one 8-bit enable/reset counter among NUM_REQ requesters.
- Each requester asks for a burst of N increments, optionally preceded by a counter clear.
- Arbitration is round-robin. The scheduler drives the counter's enable and active-high reset inputs and returns the counter value at burst end.
- Sits between requester logic and the single shared counter instance.

---
 rtl/counter_scheduler.sv | 135 +++++++++++++
 tb/tb_counter_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// Round-robin scheduler time-sharing one enable/reset counter.
// Each granted requester gets an optional clear, then a burst of increments.
module counter_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ-1:0]       req_clr,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [CNT_W-1:0]         result_value,
  output logic                     busy,
  output logic                     cnt_enable,
  output logic                     cnt_reset,
  input  logic [CNT_W-1:0]         cnt_value
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   ptr;
  logic [LEN_W-1:0]   remaining;
  logic [IDX_W-1:0]   win;
  logic               win_vld;
  logic [IDX_W:0]     sum;
  logic [LEN_W-1:0]   lens [NUM_REQ];
  logic [NUM_REQ-1:0] owner_oh;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
    assign lens[i] = req_len[i*LEN_W +: LEN_W];
  end

  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

  // Scan downward so the slot closest to ptr is the last writer.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= NREQ) sum = sum - NREQ;
      if (req[sum[IDX_W-1:0]]) begin
        win     = sum[IDX_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            owner     <= win;
            remaining <= lens[win];
          end
        end
        RUN: remaining <= remaining - 1'b1;
        DONE: begin
          if (owner == IDX_W'(NUM_REQ-1)) ptr <= '0;
          else                            ptr <= owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          if (req_clr[win])        state_nx = CLEAR;
          else if (lens[win] != 0) state_nx = RUN;
          else                     state_nx = DONE;
        end
      end
      CLEAR: state_nx = (remaining != 0) ? RUN : DONE;
      RUN:   state_nx = (remaining == 1) ? DONE : RUN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant        = '0;
    done         = '0;
    result_value = '0;
    busy         = 1'b0;
    cnt_enable   = 1'b0;
    cnt_reset    = 1'b0;
    unique case (state)
      IDLE: ;
      CLEAR: begin
        grant     = owner_oh;
        busy      = 1'b1;
        cnt_reset = 1'b1;
      end
      RUN: begin
        grant      = owner_oh;
        busy       = 1'b1;
        cnt_enable = 1'b1;
      end
      DONE: begin
        grant        = owner_oh;
        done         = owner_oh;
        busy         = 1'b1;
        result_value = cnt_value;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: burst-level model expands each grant
// into expected per-cycle outputs, compared cycle by cycle.
module tb_counter_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  req_clr;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  result_value;
  logic        busy;
  logic        cnt_enable;
  logic        cnt_reset;
  logic [7:0]  cnt;
  logic        load;
  logic [7:0]  load_val;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] g;
    logic [3:0] d;
    logic [7:0] r;
    logic       b;
    logic       e;
    logic       c;
  } exp_t;

  exp_t   expq [$];
  int     ptr_m;
  logic [7:0] cnt_m;

  always #5 clk = ~clk;

  // The shared counter the scheduler drives.
  always_ff @(posedge clk) begin
    if (load)            cnt <= load_val;
    else if (cnt_reset)  cnt <= '0;
    else if (cnt_enable) cnt <= cnt + 8'd1;
  end

  counter_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_len      (req_len),
    .req_clr      (req_clr),
    .grant        (grant),
    .done         (done),
    .result_value (result_value),
    .busy         (busy),
    .cnt_enable   (cnt_enable),
    .cnt_reset    (cnt_reset),
    .cnt_value    (cnt)
  );

  function automatic exp_t mk(input logic [3:0] g, input logic [3:0] d,
                              input logic [7:0] r, input logic b,
                              input logic e, input logic c);
    exp_t x;
    x.g = g; x.d = d; x.r = r; x.b = b; x.e = e; x.c = c;
    return x;
  endfunction

  // Burst-level model: idle gap, optional clear, len enables, done.
  task automatic build(input logic [3:0] mask, input logic [15:0] lens,
                       input logic [3:0] clrs, input bit keep,
                       input int nb);
    logic [3:0] pending;
    logic [3:0] g;
    int w;
    int len;
    int n;
    pending = mask;
    n = 0;
    expq.delete();
    while (pending != 0 && n < nb) begin
      expq.push_back(mk(4'b0, 4'b0, 8'd0, 1'b0, 1'b0, 1'b0));
      w = 0;
      for (int k = 3; k >= 0; k--)
        if (pending[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
      len = int'(lens[w*4 +: 4]);
      g = 4'b0001 << w;
      if (clrs[w]) begin
        expq.push_back(mk(g, 4'b0, 8'd0, 1'b1, 1'b0, 1'b1));
        cnt_m = 8'd0;
      end
      for (int i = 0; i < len; i++) begin
        expq.push_back(mk(g, 4'b0, 8'd0, 1'b1, 1'b1, 1'b0));
        cnt_m = cnt_m + 8'd1;
      end
      expq.push_back(mk(g, g, cnt_m, 1'b1, 1'b0, 1'b0));
      ptr_m = (w + 1) % 4;
      if (!keep) pending[w] = 1'b0;
      n++;
    end
    expq.push_back(mk(4'b0, 4'b0, 8'd0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic run_queue(input string name, input bit keep);
    exp_t x;
    int   n;
    n = expq.size();
    for (int i = 0; i < n; i++) begin
      x = expq[i];
      total++;
      if (grant !== x.g || done !== x.d || result_value !== x.r ||
          busy !== x.b || cnt_enable !== x.e || cnt_reset !== x.c) begin
        bad++;
        $display("FAIL %s cyc%0d: got g=%b d=%b r=%0d b=%b e=%b c=%b want g=%b d=%b r=%0d b=%b e=%b c=%b",
                 name, i, grant, done, result_value, busy, cnt_enable,
                 cnt_reset, x.g, x.d, x.r, x.b, x.e, x.c);
      end
      if (!keep) req = req & ~x.d;
      if (i == n - 1) req = 4'b0;
      @(negedge clk);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt_m = v;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req = 4'b0;
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
  endtask

  task automatic drive(input logic [3:0] m, input logic [15:0] l,
                       input logic [3:0] c);
    req = m;
    req_len = l;
    req_clr = c;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0 ||
        cnt_enable !== 1'b0 || cnt_reset !== 1'b0 ||
        result_value !== 8'd0) begin
      bad++;
      $display("FAIL reset: got g=%b d=%b b=%b e=%b c=%b r=%0d want all 0",
               grant, done, busy, cnt_enable, cnt_reset, result_value);
    end
    reset = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    preload(8'd120);
    drive(4'b0010, 16'h0030, 4'b0000);
    build(4'b0010, 16'h0030, 4'b0000, 1'b0, 8);
    run_queue("basic", 1'b0);
  endtask

  task automatic test_clear();
    preload(8'd50);
    drive(4'b0001, 16'h0002, 4'b0001);
    build(4'b0001, 16'h0002, 4'b0001, 1'b0, 8);
    run_queue("clear", 1'b0);
  endtask

  task automatic test_round_robin();
    apply_reset();
    preload(8'd7);
    drive(4'b1111, 16'h1111, 4'b0000);
    build(4'b1111, 16'h1111, 4'b0000, 1'b1, 5);
    run_queue("rr", 1'b1);
  endtask

  task automatic test_wrap();
    preload(8'd254);
    drive(4'b0100, 16'h0400, 4'b0000);
    build(4'b0100, 16'h0400, 4'b0000, 1'b0, 8);
    run_queue("wrap", 1'b0);
  endtask

  task automatic test_zero_len();
    preload(8'd77);
    drive(4'b1000, 16'h0000, 4'b0000);
    build(4'b1000, 16'h0000, 4'b0000, 1'b0, 8);
    run_queue("zero", 1'b0);
    preload(8'd77);
    drive(4'b0010, 16'h0000, 4'b0010);
    build(4'b0010, 16'h0000, 4'b0010, 1'b0, 8);
    run_queue("zero_clr", 1'b0);
  endtask

  task automatic test_midburst_reset();
    preload(8'd10);
    drive(4'b0100, 16'h0100, 4'b0000);
    build(4'b0100, 16'h0100, 4'b0000, 1'b0, 8);
    run_queue("pre_rst", 1'b0);
    drive(4'b1000, 16'h5000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (grant !== 4'b1000 || cnt_enable !== 1'b1) begin
      bad++;
      $display("FAIL run2: got g=%b e=%b want g=1000 e=1",
               grant, cnt_enable);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 4'b0 || cnt_enable !== 1'b0 || done !== 4'b0 ||
        busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst: got g=%b e=%b d=%b b=%b want 0",
               grant, cnt_enable, done, busy);
    end
    reset = 1'b1;
    ptr_m = 0;
    drive(4'b1001, 16'h2002, 4'b1001);
    build(4'b1001, 16'h2002, 4'b1001, 1'b0, 8);
    run_queue("post_rst", 1'b0);
  endtask

  task automatic test_random();
    logic [3:0]  m;
    logic [15:0] l;
    logic [3:0]  c;
    for (int it = 0; it < 25; it++) begin
      m = 4'($urandom_range(15, 1));
      l = 16'($urandom());
      c = 4'($urandom());
      preload(8'($urandom()));
      drive(m, l, c);
      build(m, l, c, 1'b0, 8);
      run_queue("random", 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0;
    req = 4'b0;
    req_len = 16'h0;
    req_clr = 4'b0;
    load = 1'b0;
    load_val = 8'd0;
    ptr_m = 0;
    cnt_m = 8'd0;
    test_reset();
    test_basic();
    test_clear();
    test_round_robin();
    test_wrap();
    test_zero_len();
    test_midburst_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
